// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the memory bus arbiter: FSM state encoding and default sizing.
package mem_bus_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    localparam int unsigned DEFAULT_NUM_MASTERS = 4;
    localparam int unsigned DEFAULT_MAX_HOLD    = 15;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after last_owner, wrapping, skipping excluded masters.
module mem_bus_arbiter_rr_pick #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned OW          = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [OW-1:0]          last_owner,
    input  logic [NUM_MASTERS-1:0] exclude,
    output logic                   valid,
    output logic [OW-1:0]          winner
);

    logic [NUM_MASTERS-1:0] cand;

    assign cand = req & ~exclude;

    // Offset 1 is highest priority, offset NUM_MASTERS (last_owner itself) lowest.
    always_comb begin
        int unsigned idx;
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
            idx = 32'(last_owner) + off;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!valid && cand[OW'(idx)]) begin
                valid  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for a shared memory/IO bus with locked bursts bounded by MAX_HOLD.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MAX_HOLD    = DEFAULT_MAX_HOLD
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_MASTERS-1:0]            req,
    input  logic [NUM_MASTERS-1:0]            lock,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS-1:0]            m_oe,
    output logic [NUM_MASTERS-1:0]            gnt,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic [NUM_MASTERS-1:0]            rvalid,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic                              mem_cs,
    output logic                              mem_we,
    output logic                              mem_oe,
    input  logic [DATA_WIDTH-1:0]             mem_rdata
);

    localparam int unsigned     OW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned     HW        = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [0:0]             state_q, state_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [OW-1:0]          last_q, last_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [NUM_MASTERS-1:0] rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

    logic [NUM_MASTERS-1:0] owner_oh;
    logic [NUM_MASTERS-1:0] winner_oh;
    logic [NUM_MASTERS-1:0] pick_excl;
    logic [OW-1:0]          pick_last;
    logic [OW-1:0]          pick_winner;
    logic                   pick_valid;
    logic                   others_req;
    logic                   at_limit;

    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign addr_arr[i]  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Arbitration inputs: release from an owner searches from owner+1 and excludes it when
    // it is not entitled to continue (unlocked, or hold limit hit while others wait).
    always_comb begin
        owner_oh   = NUM_MASTERS'(1) << owner_q;
        others_req = |(req & ~owner_oh);
        at_limit   = (hold_q == HOLD_LAST);
        pick_last  = (state_q == ST_OWNED) ? owner_q : last_q;
        pick_excl  = '0;
        if ((state_q == ST_OWNED) && (!lock[owner_q] || others_req)) begin
            pick_excl = owner_oh;
        end
    end

    mem_bus_arbiter_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .OW          (OW)
    ) u_rr_pick (
        .req        (req),
        .last_owner (pick_last),
        .exclude    (pick_excl),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign winner_oh = NUM_MASTERS'(1) << pick_winner;

    // Shared bus is driven straight from the owner's slice; write beats read on a conflict.
    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_oe    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ST_OWNED) begin
            mem_cs    = req[owner_q];
            mem_we    = req[owner_q] & m_we[owner_q];
            mem_oe    = req[owner_q] & m_oe[owner_q] & ~m_we[owner_q];
            mem_addr  = addr_arr[owner_q];
            mem_wdata = wdata_arr[owner_q];
        end
    end

    // Next-state, grant, hold counter and read-return logic.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        hold_d   = hold_q;
        gnt_d    = gnt_q;
        rvalid_d = '0;
        rdata_d  = rdata_q;

        if (mem_cs && mem_oe) begin
            rvalid_d = owner_oh;
            rdata_d  = mem_rdata;
        end

        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    state_d = ST_OWNED;
                    owner_d = pick_winner;
                    gnt_d   = winner_oh;
                    hold_d  = '0;
                end
            end
            default: begin
                if (!req[owner_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    last_d  = owner_q;
                    hold_d  = '0;
                end else if (lock[owner_q] && !at_limit) begin
                    hold_d = hold_q + HW'(1);
                end else begin
                    last_d = owner_q;
                    hold_d = '0;
                    if (pick_valid) begin
                        owner_d = pick_winner;
                        gnt_d   = winner_oh;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            last_q   <= OW'(NUM_MASTERS - 1);
            hold_q   <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of bus requesters; master 0 is the CPU bus interface.
REQ-002 Parameter ADDR_WIDTH, default 16: bus address width.
REQ-003 Parameter DATA_WIDTH, default 8: bus data width.
REQ-004 Parameter MAX_HOLD, default 15: maximum consecutive granted accesses per tenure.
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 req  in  NUM_MASTERS  per-master bus request, held until access done.
REQ-009 lock  in  NUM_MASTERS  per-master request to keep ownership for the next access (burst).
REQ-010 m_addr  in  NUM_MASTERS*ADDR_WIDTH  flat per-master address, master i at slice i.
REQ-011 m_wdata  in  NUM_MASTERS*DATA_WIDTH  flat per-master write data.
REQ-012 m_we  in  NUM_MASTERS  per-master write strobe.
REQ-013 m_oe  in  NUM_MASTERS  per-master read strobe.
REQ-014 gnt  out  NUM_MASTERS  one-hot registered grant.
REQ-015 rdata  out  DATA_WIDTH  registered read data, broadcast to all masters.
REQ-016 rvalid  out  NUM_MASTERS  one-cycle pulse to the master whose read data is on rdata.
REQ-017 mem_addr, mem_wdata  out  ADDR_WIDTH, DATA_WIDTH  shared bus address/data from owner.
REQ-018 mem_cs, mem_we, mem_oe  out  1 each  shared bus strobes.
REQ-019 mem_rdata  in  DATA_WIDTH  read data from memory/IO, valid in the cycle mem_oe is high.

Function
REQ-020 FSM states: IDLE (no owner) and OWNED (one owner latched in owner register).
REQ-021 IDLE: any req bit high -> latch round-robin winner into owner, set gnt one-hot, clear hold_cnt, go to OWNED; no req -> stay, gnt = 0.
REQ-022 Round-robin: search starts at last_owner+1, wraps modulo NUM_MASTERS; first requester found wins.
REQ-023 OWNED: mem_cs = req[owner]; mem_addr/mem_wdata/mem_we/mem_oe = owner's slices, combinationally; gnt stable throughout.
REQ-024 OWNED, req[owner]=0 -> no access this cycle; next state IDLE, gnt cleared, last_owner = owner.
REQ-025 OWNED, req[owner]=1 and lock[owner]=1 and hold_cnt<MAX_HOLD-1 -> access performed, hold_cnt+1, stay.
REQ-026 OWNED, req[owner]=1 and (lock[owner]=0 or hold_cnt=MAX_HOLD-1) -> access performed, last_owner = owner, re-arbitrate same edge: other requester wins -> OWNED with new owner, no bubble; none -> IDLE.
REQ-027 Forced release (hold_cnt limit) SHALL exclude current owner while any other master requests; owner alone may be regranted with hold_cnt cleared.
REQ-028 Reads: cycle with mem_cs&mem_oe -> rdata <= mem_rdata, rvalid[owner] pulses high the following cycle for exactly one cycle.
REQ-029 mem_we and mem_oe both high from the owner: write wins, mem_oe forced 0, no rvalid.
REQ-030 Non-owner strobes ignored; gnt never has more than one bit set; gnt changes only on clock edges.
REQ-031 Idle bus: mem_cs/mem_we/mem_oe = 0, mem_addr and mem_wdata = 0.
REQ-032 hold_cnt width = clog2(MAX_HOLD)+1; it SHALL never exceed MAX_HOLD-1.

Reset
REQ-033 reset_n low -> immediately: state IDLE, gnt 0, rvalid 0, rdata 0, hold_cnt 0, last_owner NUM_MASTERS-1, so master 0 wins the first arbitration.
REQ-034 Reset asserted mid-tenure or mid-read aborts the access; no rvalid pulse after reset_n rises.

Structure
REQ-035 State encoding (IDLE/OWNED) and default MAX_HOLD SHALL live in defines.vh next to existing STATE_/GROUP_ macros.
REQ-036 One sub-module rr_pick (combinational round-robin winner from req, last_owner and an exclude mask) is natural; everything else in mem_bus_arbiter.

Verification
REQ-037 After reset, req=4'b1111, lock=0 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles, one access each.
REQ-038 Master 2 req+lock held, master 0 req -> master 2 keeps gnt for exactly 15 accesses, master 0 granted next cycle.
REQ-039 Master 1 read, addr 16'h0045, mem_rdata 8'hA5 -> rdata=8'hA5 with rvalid=4'b0010 one cycle later, one cycle wide.
REQ-040 Master 3 owns bus, drops req with no other requester -> mem_cs=0 that cycle, IDLE next, gnt=0.
REQ-041 reset_n pulsed low during master 1 burst -> gnt=0 asynchronously; after release, req=4'b0011 grants master 0 first.
REQ-042 Owner asserts m_we=1 and m_oe=1, wdata 8'h3C -> mem_we=1, mem_oe=0, mem_wdata=8'h3C, no rvalid.
